// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch bridge.
package fetch_pkg;

  localparam int FETCH_AW = 32;
  localparam int FETCH_DW = 32;

  localparam logic FETCH_BUF_RST = 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_buf.sv
// Single-entry instruction buffer tagged with the PC it was fetched for.
module fetch_buf
  import fetch_pkg::*;
#(
  parameter int AW = FETCH_AW,
  parameter int DW = FETCH_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_pc,
  input  logic [DW-1:0] wr_instr,
  input  logic [AW-1:0] lookup_pc,
  output logic          hit,
  output logic [DW-1:0] rd_instr
);

  logic          buf_valid;
  logic [AW-1:0] buf_pc;
  logic [DW-1:0] buf_instr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_valid <= 1'b0;
      buf_pc    <= {AW{FETCH_BUF_RST}};
      buf_instr <= {DW{FETCH_BUF_RST}};
    end else if (wr_en) begin
      buf_valid <= 1'b1;
      buf_pc    <= wr_pc;
      buf_instr <= wr_instr;
    end
  end

  assign hit      = buf_valid && (buf_pc == lookup_pc);
  assign rd_instr = buf_instr;

endmodule

// File: rtl/inst_fetch_bridge.sv
// Turns each new fetch PC into one SRAM-like bus read and presents the
// returned word to the fetch stage, stalling it until the word is available.
module inst_fetch_bridge
  import fetch_pkg::*;
#(
  parameter int AW = FETCH_AW,
  parameter int DW = FETCH_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] pc_F,
  input  logic          stall_F,
  output logic [DW-1:0] instr_F,
  output logic          instr_valid_F,
  output logic          fetch_stall,
  output logic          inst_req,
  output logic [AW-1:0] inst_addr,
  input  logic          inst_addr_ok,
  input  logic [DW-1:0] inst_rdata,
  input  logic          inst_data_ok
);

  fetch_state_t  state, next_state;
  logic [AW-1:0] req_pc, next_req_pc;
  logic          discard, next_discard;
  logic          next_req;
  logic          buf_wr;
  logic          hit;
  logic          bypass;
  logic [DW-1:0] buf_instr;
  logic          unused_stall;

  // A stalled pipeline simply keeps pc_F steady, which keeps the buffer hitting.
  assign unused_stall = stall_F;

  fetch_buf #(
    .AW(AW),
    .DW(DW)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (buf_wr),
    .wr_pc    (req_pc),
    .wr_instr (inst_rdata),
    .lookup_pc(pc_F),
    .hit      (hit),
    .rd_instr (buf_instr)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      req_pc   <= '0;
      discard  <= 1'b0;
      inst_req <= 1'b0;
    end else begin
      state    <= next_state;
      req_pc   <= next_req_pc;
      discard  <= next_discard;
      inst_req <= next_req;
    end
  end

  always_comb begin
    next_state   = state;
    next_req_pc  = req_pc;
    next_discard = discard;
    next_req     = 1'b0;
    buf_wr       = 1'b0;
    case (state)
      IDLE: begin
        if (!hit) begin
          next_req_pc  = pc_F;
          next_discard = 1'b0;
          next_req     = 1'b1;
          next_state   = ADDR;
        end
      end
      ADDR: begin
        next_req = 1'b1;
        if (pc_F != req_pc) next_discard = 1'b1;
        if (inst_addr_ok) begin
          next_req   = 1'b0;
          next_state = DATA;
        end
      end
      DATA: begin
        if (pc_F != req_pc) next_discard = 1'b1;
        // Responses always land in the buffer under their own tag, even if stale.
        if (inst_data_ok) begin
          buf_wr       = 1'b1;
          next_discard = 1'b0;
          next_state   = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign bypass        = (state == DATA) && inst_data_ok && (req_pc == pc_F) && !discard;
  assign instr_valid_F = hit || bypass;
  assign instr_F       = bypass ? inst_rdata : buf_instr;
  assign fetch_stall   = ~instr_valid_F;
  assign inst_addr     = {req_pc[AW-1:2], 2'b00};

endmodule

// File: tb/tb_inst_fetch_bridge.sv
// Directed self-checking bench for inst_fetch_bridge; the bench plays the bus slave.
module tb_inst_fetch_bridge;

  logic        clk;
  logic        rst;
  logic [31:0] pc_F;
  logic        stall_F;
  logic [31:0] instr_F;
  logic        instr_valid_F;
  logic        fetch_stall;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic [31:0] inst_rdata;
  logic        inst_data_ok;

  int checkCount = 0;
  int passCount  = 0;
  int handshakes = 0;
  int hsBase     = 0;

  inst_fetch_bridge dut (
    .clk          (clk),
    .rst          (rst),
    .pc_F         (pc_F),
    .stall_F      (stall_F),
    .instr_F      (instr_F),
    .instr_valid_F(instr_valid_F),
    .fetch_stall  (fetch_stall),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_rdata   (inst_rdata),
    .inst_data_ok (inst_data_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts accepted bus requests so tests can prove exactly one transaction.
  always @(posedge clk) begin
    if (rst && inst_req && inst_addr_ok) handshakes++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic checkState(input string tag, input logic req, input logic valid);
    checkOutput({tag, ".req"},   32'(inst_req),      32'(req));
    checkOutput({tag, ".valid"}, 32'(instr_valid_F), 32'(valid));
    checkOutput({tag, ".stall"}, 32'(fetch_stall),   32'(!valid));
  endtask

  // Drives one cycle of inputs at the falling edge, then lets comb logic settle.
  task automatic applyStimulus(input logic [31:0] pc, input logic st, input logic aok,
                               input logic dok, input logic [31:0] rd);
    @(negedge clk);
    pc_F         = pc;
    stall_F      = st;
    inst_addr_ok = aok;
    inst_data_ok = dok;
    inst_rdata   = rd;
    #1;
  endtask

  initial begin
    rst          = 1'b0;
    pc_F         = 32'hBFC0_0000;
    stall_F      = 1'b0;
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    inst_rdata   = 32'h0;

    // Reset values
    repeat (2) @(negedge clk);
    #1;
    checkState("rst", 1'b0, 1'b0);
    checkOutput("rst.addr",  inst_addr, 32'h0);
    checkOutput("rst.instr", instr_F,   32'h0);

    // Zero-wait first miss: request in cycle 1, bypass in cycle 2
    rst = 1'b1;
    #1;
    checkState("t1.c0", 1'b0, 1'b0);
    applyStimulus(32'hBFC0_0000, 1'b0, 1'b1, 1'b0, 32'h0);
    checkState("t1.c1", 1'b1, 1'b0);
    checkOutput("t1.c1.addr", inst_addr, 32'hBFC0_0000);
    applyStimulus(32'hBFC0_0000, 1'b0, 1'b0, 1'b1, 32'h2408_0001);
    checkState("t1.c2", 1'b0, 1'b1);
    checkOutput("t1.c2.instr", instr_F, 32'h2408_0001);
    applyStimulus(32'hBFC0_0000, 1'b0, 1'b0, 1'b0, 32'h0);
    checkState("t1.hit", 1'b0, 1'b1);
    checkOutput("t1.hit.instr", instr_F, 32'h2408_0001);

    // addr_ok delayed three cycles: request held stable, one transaction
    hsBase = handshakes;
    applyStimulus(32'h0000_0104, 1'b0, 1'b0, 1'b0, 32'h0);
    checkState("t2.miss", 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(32'h0000_0104, 1'b0, 1'b0, 1'b0, 32'h0);
      checkState($sformatf("t2.wait%0d", i), 1'b1, 1'b0);
      checkOutput($sformatf("t2.wait%0d.addr", i), inst_addr, 32'h0000_0104);
    end
    applyStimulus(32'h0000_0104, 1'b0, 1'b1, 1'b0, 32'h0);
    checkState("t2.accept", 1'b1, 1'b0);
    checkOutput("t2.accept.addr", inst_addr, 32'h0000_0104);
    applyStimulus(32'h0000_0104, 1'b0, 1'b0, 1'b1, 32'h8C04_0000);
    checkState("t2.data", 1'b0, 1'b1);
    checkOutput("t2.data.instr", instr_F, 32'h8C04_0000);
    checkOutput("t2.handshakes", 32'(handshakes - hsBase), 32'd1);

    // Pipeline stall holds a valid instruction with no new requests
    for (int i = 0; i < 5; i++) begin
      applyStimulus(32'h0000_0104, 1'b1, 1'b0, 1'b0, 32'h0);
      checkState($sformatf("t4.stall%0d", i), 1'b0, 1'b1);
      checkOutput($sformatf("t4.stall%0d.instr", i), instr_F, 32'h8C04_0000);
    end

    // PC moves away while in DATA: stale response dropped, new PC fetched
    applyStimulus(32'h0000_0100, 1'b0, 1'b0, 1'b0, 32'h0);
    checkState("t3.miss", 1'b0, 1'b0);
    applyStimulus(32'h0000_0100, 1'b0, 1'b1, 1'b0, 32'h0);
    checkState("t3.addr", 1'b1, 1'b0);
    checkOutput("t3.addr.addr", inst_addr, 32'h0000_0100);
    applyStimulus(32'h0000_0200, 1'b0, 1'b0, 1'b0, 32'h0);
    checkState("t3.move", 1'b0, 1'b0);
    applyStimulus(32'h0000_0200, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    checkState("t3.stale", 1'b0, 1'b0);
    applyStimulus(32'h0000_0200, 1'b0, 1'b0, 1'b0, 32'h0);
    checkState("t3.remiss", 1'b0, 1'b0);
    applyStimulus(32'h0000_0200, 1'b0, 1'b1, 1'b0, 32'h0);
    checkState("t3.req2", 1'b1, 1'b0);
    checkOutput("t3.req2.addr", inst_addr, 32'h0000_0200);
    applyStimulus(32'h0000_0200, 1'b0, 1'b0, 1'b1, 32'h3C1D_BFC0);
    checkState("t3.data2", 1'b0, 1'b1);
    checkOutput("t3.data2.instr", instr_F, 32'h3C1D_BFC0);

    // Response for 0x104 arrives as PC moves on; returning to 0x104 hits
    applyStimulus(32'h0000_0104, 1'b0, 1'b0, 1'b0, 32'h0);
    checkState("t5.miss", 1'b0, 1'b0);
    applyStimulus(32'h0000_0104, 1'b0, 1'b1, 1'b0, 32'h0);
    checkState("t5.addr", 1'b1, 1'b0);
    applyStimulus(32'h0000_0108, 1'b0, 1'b0, 1'b1, 32'h8C04_0000);
    checkState("t5.stale", 1'b0, 1'b0);
    hsBase = handshakes;
    applyStimulus(32'h0000_0104, 1'b0, 1'b0, 1'b0, 32'h0);
    checkState("t5.hit", 1'b0, 1'b1);
    checkOutput("t5.hit.instr", instr_F, 32'h8C04_0000);
    applyStimulus(32'h0000_0104, 1'b0, 1'b0, 1'b0, 32'h0);
    checkState("t5.hold", 1'b0, 1'b1);
    checkOutput("t5.handshakes", 32'(handshakes - hsBase), 32'd0);

    // Asynchronous reset during ADDR, then a clean restart
    applyStimulus(32'h0000_0300, 1'b0, 1'b0, 1'b0, 32'h0);
    checkState("t6.miss", 1'b0, 1'b0);
    applyStimulus(32'h0000_0300, 1'b0, 1'b0, 1'b0, 32'h0);
    checkState("t6.addr", 1'b1, 1'b0);
    rst = 1'b0;
    #1;
    checkState("t6.rst", 1'b0, 1'b0);
    checkOutput("t6.rst.addr",  inst_addr, 32'h0);
    checkOutput("t6.rst.instr", instr_F,   32'h0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkState("t6.restart", 1'b0, 1'b0);
    applyStimulus(32'h0000_0300, 1'b0, 1'b1, 1'b0, 32'h0);
    checkState("t6.req", 1'b1, 1'b0);
    checkOutput("t6.req.addr", inst_addr, 32'h0000_0300);
    applyStimulus(32'h0000_0300, 1'b0, 1'b0, 1'b1, 32'hAABB_CCDD);
    checkState("t6.data", 1'b0, 1'b1);
    checkOutput("t6.data.instr", instr_F, 32'hAABB_CCDD);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
